pattern_scheduler: RTL and testbench
====================================

PATTERN_SCHEDULER -- requirements
Module: pattern_scheduler

Interface
REQ-001 Parameter ORDER_AW, default 4, order-list ROM address width (order list holds 2^ORDER_AW entries).
REQ-002 Parameter ADDR_W, default 5, pattern ROM address and pattern-length width for the note sequencer.
REQ-003 i_clk  in  1  sole clock; all logic on rising edge.
REQ-004 i_rst_n  in  1  reset, synchronous, active-low.
REQ-005 i_start  in  1  single-cycle pulse; start the song at order index 0.
REQ-006 i_stop  in  1  single-cycle pulse; abort playback.
REQ-007 i_note_done  in  1  single-cycle pulse from the note sequencer; one note of the current pattern consumed.
REQ-008 o_order_addr  out  ORDER_AW  order-list ROM address (sync ROM, 1-cycle read latency).
REQ-009 i_order_data  in  16  order entry: [4:0] pattern start addr, [9:5] pattern len (0 = end marker), [13:10] extra repeats, [15:14] ignored.
REQ-010 o_new_addr  out  ADDR_W  pattern start address to the note sequencer.
REQ-011 o_new_pattern_len  out  ADDR_W  pattern length to the note sequencer.
REQ-012 o_new_addr_valid  out  1  single-cycle load strobe to the note sequencer.
REQ-013 o_busy  out  1  high in every state except IDLE.
REQ-014 o_song_end  out  1  single-cycle pulse when an end marker terminates the song.

Function
REQ-015 States: IDLE, FETCH, LATCH, ISSUE, PLAY.
REQ-016 IDLE: i_start sampled high at edge N -> FETCH at N+1, order index = 0.
REQ-017 FETCH: o_order_addr = order index; next state LATCH.
REQ-018 LATCH: register start addr, len, repeats from i_order_data; len != 0 -> ISSUE; len == 0 -> end handling (REQ-025).
REQ-019 ISSUE: o_new_addr_valid high for exactly one cycle with latched addr/len stable; note counter cleared; next PLAY. The strobe first appears at N+3 after i_start.
REQ-020 PLAY: each i_note_done increments the note counter (ADDR_W bits); i_note_done outside PLAY is ignored.
REQ-021 Pattern complete: i_note_done while counter == len-1.
REQ-022 On completion with remaining repeats > 0: decrement repeats, go ISSUE (same addr/len, no refetch).
REQ-023 On completion with repeats == 0: order index + 1, go FETCH; index wraps from 2^ORDER_AW-1 to 0.
REQ-024 len == 1: every i_note_done in PLAY completes the pattern.
REQ-025 End marker, macro undefined: o_song_end pulses one cycle, next IDLE.
REQ-026 i_stop in any state: next state IDLE, no o_new_addr_valid or o_song_end in that cycle or after.
REQ-027 i_start and i_stop in the same cycle: stop wins; remain/return IDLE.
REQ-028 i_start while o_busy is high: ignored.
REQ-029 o_new_addr / o_new_pattern_len hold their last latched values outside ISSUE.

Reset
REQ-030 i_rst_n low at an edge: state IDLE, order index 0, note counter 0, repeats 0, all outputs 0, regardless of current state.
REQ-031 Reset deasserted: first i_start is accepted at the next edge.

Configuration
REQ-032 Macro PATTERN_SCHEDULER_LOOP_EN defined: end marker sets order index to 0 and goes FETCH, o_song_end pulses once per loop, o_busy stays high; only i_stop/reset end playback.
REQ-033 Macro undefined: end marker behaves as REQ-025.

Verification
REQ-034 Order[0] = addr 3, len 4, rep 0; order[1] = len 0; i_start at cycle 0 -> strobe at cycle 3 with addr 3 and len 4; after 4 note pulses, o_song_end pulses, then IDLE.
REQ-035 Order[0] = addr 0, len 2, rep 2 -> three strobes (addr 0, len 2), each after 2 note pulses; no refetch between them.
REQ-036 i_stop during PLAY after 1 of 4 notes -> IDLE next cycle; o_busy 0; further i_note_done produce no strobe.
REQ-037 i_rst_n low during ISSUE -> o_new_addr_valid 0 and all outputs 0 on the next cycle; a subsequent i_start replays from index 0.
REQ-038 With PATTERN_SCHEDULER_LOOP_EN, a 2-entry song plus end marker -> o_song_end pulses and the order[0] strobe recurs; o_busy never drops.
REQ-039 All 16 entries have len 1 (no marker) -> index wraps 15 -> 0; the strobe for order[0] recurs after 16 notes.

Source files
------------

// File: rtl/pattern_scheduler.sv
// pattern_scheduler: walks an order list ROM and hands pattern start/length pairs to a note sequencer.
// Optional PATTERN_SCHEDULER_LOOP_EN: an end marker restarts the song at order index 0 instead of stopping.
module pattern_scheduler #(
  parameter int ORDER_AW = 4,
  parameter int ADDR_W   = 5
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic                i_note_done,
  output logic [ORDER_AW-1:0] o_order_addr,
  input  logic [15:0]         i_order_data,
  output logic [ADDR_W-1:0]   o_new_addr,
  output logic [ADDR_W-1:0]   o_new_pattern_len,
  output logic                o_new_addr_valid,
  output logic                o_busy,
  output logic                o_song_end
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_ISSUE,
    ST_PLAY
  } state_t;

  state_t              state_reg, state_next;
  logic [ORDER_AW-1:0] index_reg, index_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [ADDR_W-1:0]   len_reg, len_next;
  logic [ADDR_W-1:0]   note_cnt_reg, note_cnt_next;
  logic [3:0]          rep_reg, rep_next;

  logic [ADDR_W-1:0]   rom_addr;
  logic [ADDR_W-1:0]   rom_len;
  logic [3:0]          rom_rep;
  logic                rom_is_marker;
  logic                pattern_done;
  logic                unused_order_bits;

  assign rom_addr          = ADDR_W'(i_order_data[4:0]);
  assign rom_len           = ADDR_W'(i_order_data[9:5]);
  assign rom_rep           = i_order_data[13:10];
  assign rom_is_marker     = (i_order_data[9:5] == 5'd0);
  assign unused_order_bits = ^i_order_data[15:14];

  // len is never zero in PLAY, so len-1 cannot underflow here
  assign pattern_done = (state_reg == ST_PLAY) && i_note_done &&
                        (note_cnt_reg == len_reg - ADDR_W'(1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg    <= ST_IDLE;
      index_reg    <= '0;
      addr_reg     <= '0;
      len_reg      <= '0;
      note_cnt_reg <= '0;
      rep_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      index_reg    <= index_next;
      addr_reg     <= addr_next;
      len_reg      <= len_next;
      note_cnt_reg <= note_cnt_next;
      rep_reg      <= rep_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    index_next    = index_reg;
    addr_next     = addr_reg;
    len_next      = len_reg;
    note_cnt_next = note_cnt_reg;
    rep_next      = rep_reg;
    case (state_reg)
      ST_IDLE: begin
        if (i_start) begin
          state_next = ST_FETCH;
          index_next = '0;
        end
      end
      ST_FETCH: state_next = ST_LATCH;
      ST_LATCH: begin
        addr_next = rom_addr;
        len_next  = rom_len;
        rep_next  = rom_rep;
        if (!rom_is_marker) begin
          state_next = ST_ISSUE;
        end else begin
`ifdef PATTERN_SCHEDULER_LOOP_EN
          index_next = '0;
          state_next = ST_FETCH;
`else
          state_next = ST_IDLE;
`endif
        end
      end
      ST_ISSUE: begin
        note_cnt_next = '0;
        state_next    = ST_PLAY;
      end
      ST_PLAY: begin
        if (pattern_done) begin
          if (rep_reg != 4'd0) begin
            rep_next   = rep_reg - 4'd1;
            state_next = ST_ISSUE;
          end else begin
            index_next = index_reg + ORDER_AW'(1);
            state_next = ST_FETCH;
          end
        end else if (i_note_done) begin
          note_cnt_next = note_cnt_reg + ADDR_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // stop overrides everything, including a simultaneous start
    if (i_stop) begin
      state_next = ST_IDLE;
    end
  end

  always_comb begin
    o_busy            = (state_reg != ST_IDLE);
    o_new_addr_valid  = (state_reg == ST_ISSUE) && !i_stop;
    o_song_end        = (state_reg == ST_LATCH) && rom_is_marker && !i_stop;
    o_order_addr      = index_reg;
    o_new_addr        = addr_reg;
    o_new_pattern_len = len_reg;
  end

endmodule

// File: tb/tb_pattern_scheduler.sv
// tb_pattern_scheduler: random and directed songs; expected strobe/song-end events are queued by a
// song-level model and checked by an independent output monitor.
module tb_pattern_scheduler;

  localparam int ORDER_AW = 4;
  localparam int ADDR_W   = 5;
`ifdef PATTERN_SCHEDULER_LOOP_EN
  localparam bit LOOP_MODE = 1'b1;
`else
  localparam bit LOOP_MODE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic note_done = 1'b0;
  logic [ORDER_AW-1:0] order_addr;
  logic [15:0] order_data = '0;
  logic [ADDR_W-1:0] new_addr, new_len;
  logic new_valid, busy, song_end;

  logic [15:0] rom [16];
  int cyc = 0;
  int ref_cyc = 0;
  int checks = 0;
  int errors = 0;
  int strobe_seen = 0;
  int end_seen = 0;

  typedef struct {
    bit is_end;
    int addr;
    int len;
    int lat;
  } ev_t;

  ev_t prog_q[$];
  ev_t exp_q[$];
  bit  natural_end;

  pattern_scheduler #(.ORDER_AW(ORDER_AW), .ADDR_W(ADDR_W)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_start(start),
    .i_stop(stop),
    .i_note_done(note_done),
    .o_order_addr(order_addr),
    .i_order_data(order_data),
    .o_new_addr(new_addr),
    .o_new_pattern_len(new_len),
    .o_new_addr_valid(new_valid),
    .o_busy(busy),
    .o_song_end(song_end)
  );

  always #5 clk = ~clk;

  // synchronous order-list ROM with one cycle of read latency
  always @(posedge clk) begin
    cyc <= cyc + 1;
    order_data <= rom[order_addr];
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic observe(input bit is_end);
    ev_t e;
    $display("cyc %0d %s addr=%0d len=%0d", cyc, is_end ? "song_end" : "strobe",
             new_addr, new_len);
    if (exp_q.size() == 0) begin
      chk("unexpected_event", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", int'(is_end), int'(e.is_end));
      if (!is_end && !e.is_end) begin
        chk("strobe_addr", int'(new_addr), e.addr);
        chk("strobe_len", int'(new_len), e.len);
      end
      chk("event_latency", cyc - ref_cyc, e.lat);
    end
    ref_cyc = cyc;
  endtask

  // monitor: every strobe / song-end is matched against the head of the scoreboard
  always @(negedge clk) begin
    if (new_valid) begin
      strobe_seen++;
      observe(1'b0);
    end
    if (song_end) begin
      end_seen++;
      observe(1'b1);
    end
  end

  function automatic logic [15:0] mk(input int addr, input int len, input int rep, input int hi);
    logic [15:0] w;
    w[4:0]   = addr[4:0];
    w[9:5]   = len[4:0];
    w[13:10] = rep[3:0];
    w[15:14] = hi[1:0];
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = '0;
  endtask

  // Song-level reference: a fetched entry strobes 3 cycles after its trigger, a repeat 1 cycle,
  // an end marker pulses 2 cycles after its trigger.
  task automatic build_program(input int cap);
    int idx;
    int len;
    int rep;
    logic [15:0] w;
    ev_t e;
    prog_q.delete();
    natural_end = 1'b0;
    idx = 0;
    while (prog_q.size() < cap) begin
      w   = rom[idx];
      len = int'(w[9:5]);
      rep = int'(w[13:10]);
      if (len == 0) begin
        e = '{1'b1, 0, 0, 2};
        prog_q.push_back(e);
        if (!LOOP_MODE) begin
          natural_end = 1'b1;
          break;
        end
        idx = 0;
      end else begin
        for (int r = 0; r <= rep && prog_q.size() < cap; r++) begin
          e = '{1'b0, int'(w[4:0]), len, (r == 0) ? 3 : 1};
          prog_q.push_back(e);
        end
        idx = (idx + 1) % 16;
      end
    end
  endtask

  task automatic send_notes(input int n);
    for (int k = 0; k < n; k++) begin
      note_done = 1'b1;
      if ($urandom_range(0, 3) == 0) start = 1'b1;
      ref_cyc = cyc;
      tick();
      note_done = 1'b0;
      start = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic wait_for(input bit want_end, input int target, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 64; t++) begin
      if ((want_end ? end_seen : strobe_seen) >= target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk(want_end ? "wait_song_end" : "wait_strobe", 0, 1);
  endtask

  // partial < 0: random number of notes (fewer than len) before stopping a truncated song
  task automatic run_song(input int cap, input int partial);
    bit ok;
    int ns, ne, sb, eb, notes;
    build_program(cap);
    for (int i = 0; i < prog_q.size(); i++) exp_q.push_back(prog_q[i]);
    repeat ($urandom_range(0, 2)) begin
      note_done = 1'b1;
      tick();
      note_done = 1'b0;
    end
    sb = strobe_seen;
    eb = end_seen;
    ns = 0;
    ne = 0;
    ok = 1'b1;
    start = 1'b1;
    ref_cyc = cyc;
    tick();
    start = 1'b0;
    for (int i = 0; i < prog_q.size(); i++) begin
      if (prog_q[i].is_end) begin
        ne++;
        wait_for(1'b1, eb + ne, ok);
      end else begin
        ns++;
        wait_for(1'b0, sb + ns, ok);
      end
      if (!ok) break;
      chk("busy_during_song", int'(busy), int'(!prog_q[i].is_end || LOOP_MODE));
      if (!prog_q[i].is_end) begin
        notes = prog_q[i].len;
        if (i == prog_q.size() - 1 && !natural_end)
          notes = (partial >= 0) ? partial : int'($urandom_range(0, prog_q[i].len - 1));
        send_notes(notes);
      end
    end
    if (!(natural_end && ok)) begin
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("busy_after_stop", int'(busy), 0);
    end
    repeat (3) begin
      note_done = 1'b1;
      tick();
      note_done = 1'b0;
      tick();
    end
    chk("leftover_expected", exp_q.size(), 0);
    exp_q.delete();
    chk("idle_after_song", int'(busy), 0);
  endtask

  initial begin
    clear_rom();
    rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_busy", int'(busy), 0);
    chk("reset_valid", int'(new_valid), 0);
    chk("reset_song_end", int'(song_end), 0);
    chk("reset_order_addr", int'(order_addr), 0);
    chk("reset_new_addr", int'(new_addr), 0);
    chk("reset_new_len", int'(new_len), 0);
    rst_n = 1'b1;

    // single pattern then end marker; start issued right after reset release
    rom[0] = mk(3, 4, 0, 0);
    run_song(50, -1);

    // one entry played three times without refetch
    clear_rom();
    rom[0] = mk(0, 2, 2, 3);
    run_song(50, -1);

    // stop after 1 of 4 notes
    clear_rom();
    rom[0] = mk(3, 4, 0, 0);
    run_song(1, 1);

    // start and stop together in IDLE: stop wins
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk("start_stop_busy", int'(busy), 0);
    tick();
    chk("start_stop_busy_later", int'(busy), 0);

    // reset while in ISSUE, then replay from index 0
    exp_q.push_back('{1'b0, 3, 4, 3});
    start = 1'b1;
    ref_cyc = cyc;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("rst_issue_valid", int'(new_valid), 0);
    chk("rst_issue_busy", int'(busy), 0);
    chk("rst_issue_song_end", int'(song_end), 0);
    chk("rst_issue_order_addr", int'(order_addr), 0);
    chk("rst_issue_new_addr", int'(new_addr), 0);
    chk("rst_issue_new_len", int'(new_len), 0);
    chk("rst_issue_strobe_seen", exp_q.size(), 0);
    exp_q.delete();
    rst_n = 1'b1;
    run_song(50, -1);

    // sixteen single-note entries, no marker: index wraps back to 0
    for (int i = 0; i < 16; i++) rom[i] = mk(i, 1, 0, i);
    run_song(20, 0);

    // random order lists
    repeat (30) begin
      for (int i = 0; i < 16; i++)
        rom[i] = mk($urandom_range(0, 31),
                    ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 6),
                    $urandom_range(0, 3), $urandom_range(0, 3));
      run_song($urandom_range(1, 30), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
